data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the byte-addressed data memory (big-endian words, base address 1024, 256 bytes).
- Requester 0 is the CPU MEM stage; requester 1 is the debug/DMA loader.
- Latches one request at a time, range- and alignment-checks it, drives the memory for exactly one cycle, then returns a registered ack, error flag and read data.

Parameters:
- BASE_ADDR, 1024, byte address of memory byte 0
- MEM_BYTES, 256, memory size in bytes
- DATA_W, 32, data and address width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- m0_req  in  1  requester 0 request; held until m0_ack
- m0_we  in  1  requester 0: 1=write, 0=read
- m0_addr  in  32  requester 0 byte address
- m0_wdata  in  32  requester 0 write data
- m0_ack  out  1  requester 0 one-cycle completion pulse
- m0_err  out  1  requester 0 error, valid with m0_ack
- m0_rdata  out  32  requester 0 read data, valid with m0_ack
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_err, m1_rdata: same as m0_*, for requester 1
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable
- mem_address  out  32  memory byte address
- mem_data  out  32  memory write data
- mem_result  in  32  memory combinational read data
- busy  out  1  high whenever state != IDLE
- owner  out  1  requester owning the current transaction

Behaviour:
- Reset (rst=0, async): state=IDLE, last_owner=1 (so m0 wins the first tie).
  - All outputs are 0, including mem_read and mem_write immediately.
  - Latched address, data and we registers are cleared.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - At a clock edge where any req is high, pick the winner.
    - Single requester: that requester wins.
    - Both requesting: winner = !last_owner. last_owner and owner are set to the winner.
  - Latch the winner's addr, we and wdata.
  - Compute addr_ok = (addr >= BASE_ADDR) && (addr <= BASE_ADDR+MEM_BYTES-4) && (addr[1:0]==0). Use 32-bit unsigned compares; no wrap.
  - addr_ok -> ACCESS. Otherwise -> RESP with err latched.
- ACCESS (exactly 1 cycle):
  - mem_address and mem_data come from the latched registers.
  - mem_read = !we; mem_write = we. Both are decoded combinationally from state and the latched we.
  - On the closing edge, mem_result is captured into rdata_q when !we; otherwise rdata_q=0.
  - Next state is RESP.
- RESP (1 cycle):
  - m<owner>_ack=1, m<owner>_err=err_q, m<owner>_rdata=rdata_q.
  - The non-owner's ack/err/rdata stay 0. Next state is IDLE.
- Outside RESP, all ack/err/rdata outputs are 0. Outside ACCESS, mem_read=mem_write=0 and mem_address=mem_data=0.
- Latency, counted from the IDLE edge that samples req (cycle N):
  - Valid access: ACCESS in cycle N+1, ack in cycle N+2.
  - Error: ack+err in cycle N+1, and no memory strobe is issued.
- Requester rule: deassert req in the cycle after ack. A req still high when the FSM returns to IDLE is a new transaction.
- With both requesters held high continuously, grants alternate strictly 0,1,0,1.
- A requester that drops req mid-transaction does not abort it: the transaction completes and ack still pulses.
- A req arriving while busy is ignored until the FSM is back in IDLE. There is no queueing.
- Reset asserted during ACCESS with a write: mem_write falls asynchronously and no ack is issued. Whether that write reaches memory is undefined to requesters.
- Each write produces exactly one mem_write cycle.

Decomposition:
- Package data_mem_pkg:
  - BASE_ADDR and MEM_BYTES constants
  - state enum {IDLE, ACCESS, RESP}
  - owner_t (1 bit)
- One sub-module, rr_arbiter2:
  - Inputs: req0, req1, last_owner.
  - Outputs: grant_valid, grant_id.
  - Combinational; holds no state.

Test Plan:
- Reset then m0 read at 1024 on cleared memory -> ack exactly 2 cycles after the sampling edge, rdata=0, err=0, mem_read high for one cycle with mem_address=1024.
- m0 write 0xDEADBEEF to 1028, then m1 read at 1028 -> one mem_write cycle with address 1028 and data 0xDEADBEEF; m1_rdata=0xDEADBEEF, m0 outputs stay 0 during m1_ack.
- m0_req and m1_req both held high for 12 cycles -> acks to m0,m1,m0,m1 at cycles 2,5,8,11 after the first sampling edge; m0 is granted first after reset.
- Reads at 1020, 1280, 1026 and 1277 -> ack+err in cycle N+1, rdata=0, mem_read/mem_write never asserted. A read at 1276 -> err=0 with a normal 2-cycle latency.
- m1 write at 1032 with rst pulled low during ACCESS -> mem_write drops immediately, no ack, busy=0. After release, a simultaneous m0/m1 request grants m0.
- m0 drops req in the ACCESS cycle -> m0_ack still pulses in RESP. A new m1_req raised during ACCESS is granted only at the next IDLE edge.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared constants and types for the data-memory arbiter slice.
package data_mem_pkg;
   localparam int unsigned BASE_ADDR = 1024;
   localparam int unsigned MEM_BYTES = 256;
   localparam int unsigned DATA_W    = 32;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
   typedef logic owner_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick; the requester that did not win last time wins a tie.
module rr_arbiter2
   import data_mem_pkg::*;
(
   input  logic   req0,
   input  logic   req1,
   input  owner_t last_owner,
   output logic   grant_valid,
   output owner_t grant_id
);
   always_comb begin
      grant_valid = req0 | req1;
      grant_id    = (req0 & req1) ? ~last_owner : req1;
   end
endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter/sequencer for two requesters sharing the byte-addressed
// data memory: latch one request, range-check it, access once, then ack.
module data_mem_arbiter #(
   parameter int unsigned BASE_ADDR = data_mem_pkg::BASE_ADDR,
   parameter int unsigned MEM_BYTES = data_mem_pkg::MEM_BYTES,
   parameter int unsigned DATA_W    = data_mem_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [DATA_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_ack,
   output logic              m0_err,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [DATA_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_ack,
   output logic              m1_err,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_data,
   input  logic [DATA_W-1:0] mem_result,
   output logic              busy,
   output logic              owner
);
   import data_mem_pkg::state_e;
   import data_mem_pkg::owner_t;
   import data_mem_pkg::IDLE;
   import data_mem_pkg::ACCESS;
   import data_mem_pkg::RESP;

   localparam logic [DATA_W-1:0] ADDR_LO = DATA_W'(BASE_ADDR);
   localparam logic [DATA_W-1:0] ADDR_HI = DATA_W'(BASE_ADDR + MEM_BYTES - 4);

   state_e            state_q;
   owner_t            owner_q, last_owner_q;
   logic [DATA_W-1:0] addr_q, wdata_q, rdata_q;
   logic              we_q, err_q;

   logic              grant_valid;
   owner_t            grant_id;
   logic [DATA_W-1:0] sel_addr, sel_wdata;
   logic              sel_we, addr_ok;

   rr_arbiter2 u_arb (
      .req0        (m0_req),
      .req1        (m1_req),
      .last_owner  (last_owner_q),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   always_comb begin
      sel_addr  = grant_id ? m1_addr  : m0_addr;
      sel_wdata = grant_id ? m1_wdata : m0_wdata;
      sel_we    = grant_id ? m1_we    : m0_we;
      addr_ok   = (sel_addr >= ADDR_LO) && (sel_addr <= ADDR_HI) && (sel_addr[1:0] == 2'b00);
   end

   // last_owner resets to 1 so requester 0 wins the first tie.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         last_owner_q <= 1'b1;
         addr_q       <= '0;
         wdata_q      <= '0;
         we_q         <= 1'b0;
         err_q        <= 1'b0;
         rdata_q      <= '0;
      end else begin
         case (state_q)
            IDLE: if (grant_valid) begin
               owner_q      <= grant_id;
               last_owner_q <= grant_id;
               addr_q       <= sel_addr;
               wdata_q      <= sel_wdata;
               we_q         <= sel_we;
               err_q        <= ~addr_ok;
               rdata_q      <= '0;
               state_q      <= addr_ok ? ACCESS : RESP;
            end
            ACCESS: begin
               rdata_q <= we_q ? '0 : mem_result;
               state_q <= RESP;
            end
            RESP:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   logic in_acc, in_resp;

   always_comb begin
      in_acc      = (state_q == ACCESS);
      in_resp     = (state_q == RESP);
      mem_read    = in_acc & ~we_q;
      mem_write   = in_acc &  we_q;
      mem_address = in_acc ? addr_q  : '0;
      mem_data    = in_acc ? wdata_q : '0;
      m0_ack      = in_resp & ~owner_q;
      m1_ack      = in_resp &  owner_q;
      m0_err      = m0_ack & err_q;
      m1_err      = m1_ack & err_q;
      m0_rdata    = m0_ack ? rdata_q : '0;
      m1_rdata    = m1_ack ? rdata_q : '0;
      busy        = (state_q != IDLE);
      owner       = owner_q;
   end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench: table of single transactions plus hand-written
// round-robin, reset-during-access and drop-mid-transaction sequences.
module tb_data_mem_arbiter;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
   logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
   logic        m0_ack, m0_err, m1_ack, m1_err;
   logic [31:0] m0_rdata, m1_rdata;
   logic        mem_read, mem_write, busy, owner;
   logic [31:0] mem_address, mem_data, mem_result;

   data_mem_arbiter dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_data(mem_data), .mem_result(mem_result), .busy(busy), .owner(owner)
   );

   always #5 clk = ~clk;

   // Big-endian byte memory at 1024..1279
   logic [7:0]  mem [0:255];
   logic        mem_clr = 1'b1;
   logic        in_rng;
   logic [7:0]  mo;
   assign in_rng = (mem_address >= 32'd1024) && (mem_address <= 32'd1276);
   assign mo     = 8'(mem_address - 32'd1024);
   assign mem_result = in_rng ? {mem[mo], mem[mo+8'd1], mem[mo+8'd2], mem[mo+8'd3]} : 32'h0;

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      end else if (mem_write && in_rng) begin
         mem[mo]      <= mem_data[31:24];
         mem[mo+8'd1] <= mem_data[23:16];
         mem[mo+8'd2] <= mem_data[15:8];
         mem[mo+8'd3] <= mem_data[7:0];
      end
   end

   typedef struct { logic id; logic we; logic [31:0] addr; logic [31:0] wdata; logic err; } vec_t;
   typedef struct { logic id; logic err; logic [31:0] rdata; } exp_t;

   exp_t        sbq[$];
   exp_t        mon_e;
   logic [31:0] shadow [0:63];
   int          checks = 0;
   int          failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] shadow_rd(input logic [31:0] a);
      logic [31:0] off;
      off = a - 32'd1024;
      return shadow[off[7:2]];
   endfunction

   // Scoreboard: every ack pops the oldest expected response
   always @(negedge clk) begin
      if (m0_ack || m1_ack) begin
         chk("ack_onehot", {31'b0, m0_ack & m1_ack}, 32'h0);
         if (sbq.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_ack: got m0_ack=%0b m1_ack=%0b expected none", m0_ack, m1_ack);
         end else begin
            mon_e = sbq.pop_front();
            chk("ack_id",        {31'b0, m1_ack}, {31'b0, mon_e.id});
            chk("ack_err",       {31'b0, mon_e.id ? m1_err : m0_err}, {31'b0, mon_e.err});
            chk("ack_rdata",     mon_e.id ? m1_rdata : m0_rdata, mon_e.rdata);
            chk("nonowner_err",  {31'b0, mon_e.id ? m0_err : m1_err}, 32'h0);
            chk("nonowner_data", mon_e.id ? m0_rdata : m1_rdata, 32'h0);
         end
      end
   end

   task automatic drive(input logic id, input logic req, input logic we,
                        input logic [31:0] addr, input logic [31:0] wdata);
      if (id) begin m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; end
      else    begin m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata; end
   endtask

   task automatic run_txn(input vec_t v, input int idx);
      exp_t e;
      int   lat, nrd, nwr;
      e.id = v.id; e.err = v.err;
      e.rdata = (v.we || v.err) ? 32'h0 : shadow_rd(v.addr);
      @(negedge clk);
      drive(v.id, 1'b1, v.we, v.addr, v.wdata);
      sbq.push_back(e);
      lat = 0; nrd = 0; nwr = 0;
      for (int k = 1; k <= 6 && lat == 0; k++) begin
         @(negedge clk);
         if (mem_read) begin
            nrd++;
            chk($sformatf("v%0d_rd_addr", idx), mem_address, v.addr);
         end
         if (mem_write) begin
            nwr++;
            chk($sformatf("v%0d_wr_addr", idx), mem_address, v.addr);
            chk($sformatf("v%0d_wr_data", idx), mem_data, v.wdata);
         end
         if ((v.id ? m1_ack : m0_ack) == 1'b1) lat = k;
      end
      drive(v.id, 1'b0, 1'b0, 32'h0, 32'h0);
      chk($sformatf("v%0d_latency", idx), lat, v.err ? 1 : 2);
      chk($sformatf("v%0d_nread", idx),  nrd, (!v.err && !v.we) ? 1 : 0);
      chk($sformatf("v%0d_nwrite", idx), nwr, (!v.err &&  v.we) ? 1 : 0);
      if (v.we && !v.err) shadow[(v.addr - 32'd1024) >> 2] = v.wdata;
   endtask

   task automatic reset_pulse();
      @(negedge clk); rst = 1'b0;
      @(negedge clk); rst = 1'b1;
   endtask

   vec_t vt [13];

   initial begin
      vt[0]  = '{0, 0, 32'd1024, 32'h0,        0};
      vt[1]  = '{0, 1, 32'd1028, 32'hDEADBEEF, 0};
      vt[2]  = '{1, 0, 32'd1028, 32'h0,        0};
      vt[3]  = '{0, 0, 32'd1020, 32'h0,        1};
      vt[4]  = '{1, 0, 32'd1280, 32'h0,        1};
      vt[5]  = '{0, 0, 32'd1026, 32'h0,        1};
      vt[6]  = '{1, 0, 32'd1277, 32'h0,        1};
      vt[7]  = '{0, 0, 32'd1276, 32'h0,        0};
      vt[8]  = '{1, 1, 32'd1276, 32'h12345678, 0};
      vt[9]  = '{0, 0, 32'd1276, 32'h0,        0};
      vt[10] = '{0, 1, 32'd1024, 32'hA5A55A5A, 0};
      vt[11] = '{1, 0, 32'd1024, 32'h0,        0};
      vt[12] = '{1, 1, 32'd1280, 32'h11111111, 1};
      for (int i = 0; i < 64; i++) shadow[i] = 32'h0;

      // Reset state
      #12;
      chk("rst_busy",  {31'b0, busy}, 0);
      chk("rst_owner", {31'b0, owner}, 0);
      chk("rst_strobes", {30'b0, mem_read, mem_write}, 0);
      chk("rst_mem_addr", mem_address, 0);
      chk("rst_acks", {28'b0, m0_ack, m1_ack, m0_err, m1_err}, 0);
      @(negedge clk); mem_clr = 1'b0;
      @(negedge clk); rst = 1'b1;

      for (int i = 0; i < 13; i++) run_txn(vt[i], i);
      repeat (2) @(negedge clk);
      chk("table_sb_empty", sbq.size(), 0);

      // Reset during a write ACCESS: strobe drops at once, no ack follows
      @(negedge clk);
      drive(1, 1'b1, 1'b1, 32'd1032, 32'hCAFEF00D);
      @(negedge clk);
      chk("rstacc_write_hi", {31'b0, mem_write}, 1);
      chk("rstacc_addr", mem_address, 32'd1032);
      rst = 1'b0;
      #1;
      chk("rstacc_write_lo", {31'b0, mem_write}, 0);
      chk("rstacc_busy", {31'b0, busy}, 0);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      drive(0, 1'b1, 1'b0, 32'd1024, 32'h0);
      drive(1, 1'b1, 1'b0, 32'd1028, 32'h0);
      sbq.push_back('{0, 0, shadow[0]});
      @(negedge clk);
      chk("rstacc_first_owner", {31'b0, owner}, 0);
      @(negedge clk);
      chk("rstacc_m0_ack", {31'b0, m0_ack}, 1);
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (2) @(negedge clk);
      chk("rstacc_sb_empty", sbq.size(), 0);

      // Both held high: strict alternation starting with m0
      reset_pulse();
      @(negedge clk);
      drive(0, 1'b1, 1'b0, 32'd1024, 32'h0);
      drive(1, 1'b1, 1'b0, 32'd1028, 32'h0);
      for (int j = 0; j < 4; j++) sbq.push_back('{j[0], 0, shadow[j % 2]});
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (k == 2 || k == 8)       chk($sformatf("rr_k%0d", k), {30'b0, m1_ack, m0_ack}, 32'h1);
         else if (k == 5 || k == 11) chk($sformatf("rr_k%0d", k), {30'b0, m1_ack, m0_ack}, 32'h2);
         else                        chk($sformatf("rr_k%0d", k), {30'b0, m1_ack, m0_ack}, 32'h0);
         if (k == 12) begin
            drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
            drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
         end
      end
      repeat (3) @(negedge clk);
      chk("rr_sb_empty", sbq.size(), 0);

      // m0 drops req in ACCESS; m1 raised during ACCESS waits for IDLE
      @(negedge clk);
      drive(0, 1'b1, 1'b0, 32'd1276, 32'h0);
      sbq.push_back('{0, 0, shadow[63]});
      @(negedge clk);
      chk("drop_access", {31'b0, mem_read}, 1);
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1, 1'b1, 1'b0, 32'd1024, 32'h0);
      sbq.push_back('{1, 0, shadow[0]});
      @(negedge clk);
      chk("drop_m0_ack", {31'b0, m0_ack}, 1);
      chk("drop_m1_wait", {31'b0, m1_ack}, 0);
      @(negedge clk);
      chk("drop_idle", {31'b0, busy}, 0);
      @(negedge clk);
      chk("drop_m1_owner", {31'b0, owner}, 1);
      chk("drop_m1_addr", mem_address, 32'd1024);
      @(negedge clk);
      chk("drop_m1_ack", {31'b0, m1_ack}, 1);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (3) @(negedge clk);
      chk("drop_sb_empty", sbq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
